// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline controller: PC register, IF/ID register, and the EX-stage
// hazard feedback (flag/rd/ex_kill) plus saturating stall/flush event counters.
module pipe_front_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_ins,
    input  logic             flush,
    input  logic             bubble,
    input  logic             pc_en,
    input  logic [1:0]       tag,
    output logic [31:0]      pc,
    output logic [31:0]      id_ins,
    output logic [31:0]      id_pc,
    output logic [1:0]       flag,
    output logic [4:0]       rd,
    output logic             ex_kill,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]       TAG_LOAD   = 2'd1;
    localparam logic [1:0]       TAG_BRANCH = 2'd2;
    localparam logic [1:0]       TAG_JUMP   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] pc_nxt;
    logic [31:0] id_ins_nxt;
    logic [31:0] id_pc_nxt;
    logic [1:0]  flag_nxt;
    logic [4:0]  rd_nxt;
    logic        ex_kill_nxt;
    logic        flush_eff;

    // Redirect targets are relative to the instruction sitting in ID.
    assign pc4    = id_pc + 32'd4;
    assign br_off = {{14{id_ins[15]}}, id_ins[15:0], 2'b00};
    assign bt     = pc4 + br_off;
    assign jt     = {pc4[31:28], id_ins[25:0], 2'b00};

    // A stall masks a simultaneous flush; it is re-issued once the stall drops.
    assign flush_eff = pc_en & ~flush;

    always_comb begin
        pc_nxt = pc;
        if (pc_en) begin
            case (tag)
                TAG_JUMP:   pc_nxt = jt;
                TAG_BRANCH: pc_nxt = bt;
                default:    pc_nxt = pc + 32'd4;
            endcase
        end
    end

    always_comb begin
        id_ins_nxt = id_ins;
        id_pc_nxt  = id_pc;
        if (pc_en) begin
            id_ins_nxt = flush ? if_ins : 32'h0000_0000;
            id_pc_nxt  = pc;
        end
    end

    always_comb begin
        flag_nxt    = 2'd0;
        rd_nxt      = 5'd0;
        ex_kill_nxt = 1'b1;
        if (bubble) begin
            flag_nxt    = tag;
            ex_kill_nxt = 1'b0;
            if (tag == TAG_LOAD) begin
                rd_nxt = id_ins[20:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            id_ins  <= 32'h0000_0000;
            id_pc   <= 32'h0000_0000;
            flag    <= 2'd0;
            rd      <= 5'd0;
            ex_kill <= 1'b1;
        end else begin
            pc      <= pc_nxt;
            id_ins  <= id_ins_nxt;
            id_pc   <= id_pc_nxt;
            flag    <= flag_nxt;
            rd      <= rd_nxt;
            ex_kill <= ex_kill_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_eff && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_front_ctrl.md
# pipe_front_ctrl

Front-end pipeline controller for the 5-stage MIPS core: owns the PC register, the IF/ID register and the hazard feedback registers (`flag`, `rd`). It acts on the active-low `flush`, `bubble` and `pc_en` commands and the `tag` classification from the ID-stage hazard unit. It also returns the registered tag and load destination of the instruction that just entered EX, closing the hazard loop. It sits between instruction memory, the ID stage and the ID/EX register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the saturating stall/flush event counters

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- if_ins  in  32  instruction fetched at `pc`
- flush  in  1  active-low: 0 = replace IF/ID contents with NOP
- bubble  in  1  active-low: 0 = kill the instruction moving ID→EX
- pc_en  in  1  active-low stall: 0 = hold PC and IF/ID
- tag  in  2  class of `id_ins`: 0 other, 1 load, 2 taken branch, 3 jump
- pc  out  32  fetch address
- id_ins  out  32  IF/ID instruction, to decoder and hazard unit
- id_pc  out  32  PC of `id_ins`
- flag  out  2  tag of the instruction now in EX (0 if killed)
- rd  out  5  load destination (`rt`) of the instruction in EX, 0 if none
- ex_kill  out  1  1 = ID/EX register must hold a NOP this cycle
- stall_cnt  out  CNT_W  cycles with `pc_en`=0, saturating
- flush_cnt  out  CNT_W  cycles with an effective IF/ID flush, saturating

## Operation
- Combinational targets:
  - pc4 = id_pc + 4.
  - Branch target bt = pc4 + (sign-extended id_ins[15:0] << 2), modulo 2^32.
  - Jump target jt = {pc4[31:28], id_ins[25:0], 2'b00}.
- PC update, in priority order:
  - rst: RESET_PC.
  - pc_en=0: hold.
  - tag=3: jt.
  - tag=2: bt.
  - Otherwise: pc+4, wrapping at 2^32.
- IF/ID update, in priority order:
  - rst: id_ins=0, id_pc=0.
  - pc_en=0: hold. The stall dominates `flush`, so a simultaneous flush is discarded and re-evaluated after the stall.
  - flush=0: id_ins=32'h0 (NOP), id_pc=pc.
  - Otherwise: id_ins=if_ins, id_pc=pc.
- Feedback/EX control, in priority order:
  - rst: flag=0, rd=0, ex_kill=1.
  - bubble=0: flag=0, rd=0, ex_kill=1.
  - Otherwise: flag=tag, ex_kill=0. rd=id_ins[20:16] when tag=1, else rd=0.
- A stall (pc_en=0) arrives together with bubble=0, so the load in EX advances while the dependent instruction waits in ID.
- Counters:
  - Reset to 0.
  - stall_cnt increments when pc_en=0.
  - flush_cnt increments when flush=0 and pc_en=1.
  - Both hold at 2^CNT_W−1.
- No internal FSM beyond these registers. The hazard loop is IF/ID → hazard unit → commands → register update.
- The `flag` encodings are exactly the `tag` encodings. Values 2/3 in `flag` tell the hazard unit that the ID instruction is wrong-path.

## Timing
- All state updates happen on the rising edge of clk. Outputs are registered, with no combinational path from inputs to outputs.
- Reset values:
  - pc=RESET_PC, id_ins=0, id_pc=0.
  - flag=0, rd=0, ex_kill=1.
  - stall_cnt=0, flush_cnt=0.
- rst asserted mid-operation overrides every command in that cycle. The first fetch after release uses RESET_PC.
- Redirect latency: a taken branch/jump sampled in ID at edge N puts the target on `pc` after edge N. The wrong-path instruction fetched in cycle N is flushed at the same edge when flush=0. Net penalty is 1 cycle.
- Load-use: one stall cycle per pc_en=0 cycle. `pc` and `id_ins` hold, and `flag`/`rd` are cleared at that edge when bubble=0.
- Consecutive stalls hold indefinitely with no drift of pc or id_pc.
- Branch at id_pc=32'hFFFF_FFFC: pc4 wraps to 0, and the target is computed modulo 2^32.

## Test plan
- Reset: assert rst 2 cycles with random inputs → pc=RESET_PC, id_ins=0, flag=0, rd=0, ex_kill=1, counters 0.
- Sequential fetch: flush=bubble=pc_en=1, tag=0, if_ins=32'h0000_0020 → pc advances 0,4,8; id_ins=32'h20 and id_pc=0 after the first edge.
- Taken beq: id_pc=32'h40, id_ins=32'h1000_0003, tag=2, flush=0 → next pc=32'h50, id_ins=0, flush_cnt+1, flag=2.
- Jump: id_pc=32'h1000_0008, id_ins=32'h0800_0100, tag=3, flush=0 → next pc=32'h1000_0400, id_ins=0, flag=3.
- Load-use: load in ID with id_ins=32'h8C08_0000 and tag=1 → flag=1, rd=8. The next cycle applies pc_en=0, bubble=0, flush=0 → pc and id_ins unchanged, flag=0, rd=0, ex_kill=1, stall_cnt=1, flush_cnt unchanged.
- Saturation: CNT_W=2, hold pc_en=0 for 6 cycles → stall_cnt=3 and stays 3. Assert rst mid-stall → all reset values next edge.
